// File: rtl/xbar_slave_responder.sv
// Crossbar slave endpoint: services a packed master word against a local register file
// after WAIT_CYC wait states. Optional XBAR_SLV_STATS_EN adds read/write completion counters.
module xbar_slave_responder #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [65:0] m_in,
  output logic [32:0] s_out
`ifdef XBAR_SLV_STATS_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
`endif
);

  // state  | meaning
  // S_IDLE | no transaction in flight, waiting for req
  // S_WAIT | request accepted, counting wait states
  // S_RESP | ack cycle; write committed / read data presented
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_resp;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] mem [DEPTH];

  logic             req;
  logic             cmd;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [IDX_W-1:0] idx;

  assign req   = m_in[65];
  assign cmd   = m_in[64];
  assign addr  = m_in[63:32];
  assign wdata = m_in[31:0];
  assign idx   = addr[IDX_W+1:2];

  // Upper address bits (incl. the crossbar select) and byte offset alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          cnt_nxt = '0;
          if (WAIT_CYC == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_RESP: begin
        // req here is the still-held current request, not a new one.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      rdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= enter_resp;
      // rdata stays zero outside a read ack so slave words can be OR-combined.
      rdata <= (enter_resp && !cmd) ? mem[idx] : '0;
      if (enter_resp && cmd) begin
        mem[idx] <= wdata;
      end
    end
  end

  assign s_out = {ack, rdata};

`ifdef XBAR_SLV_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (enter_resp) begin
      if (cmd && (wr_cnt != 16'hFFFF)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (!cmd && (rd_cnt != 16'hFFFF)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xbar_slave_responder.sv
// Self-checking bench for xbar_slave_responder: transaction-level reference model compared
// every cycle, plus directed transactions with literal expectations.
module tb_xbar_slave_responder;

  localparam int DEPTH    = 16;
  localparam int IDX_W    = 4;
  localparam int WAIT_CYC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        cmd = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [65:0] m_in;
  logic [32:0] s_out;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  assign m_in = {req, cmd, addr, wdata};

`ifdef XBAR_SLV_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;
  xbar_slave_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .reset(reset), .m_in(m_in), .s_out(s_out), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt));
`else
  xbar_slave_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .reset(reset), .m_in(m_in), .s_out(s_out));
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a transaction is a run of sampled-high req; it completes WAIT_CYC
  // edges after its first sample unless req is seen low first or reset intervenes.
  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_left;
  bit          m_ack;
  logic [31:0] m_rdata;
  int          m_rd, m_wr;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy = 0; m_left = 0; m_ack = 0; m_rdata = '0; m_rd = 0; m_wr = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end else if (m_ack) begin
        m_ack = 0; m_rdata = '0; m_busy = 0;
      end else begin
        if (!m_busy && req) begin
          m_busy = 1; m_left = WAIT_CYC;
        end else if (m_busy && !req) begin
          m_busy = 0;
        end else if (m_busy) begin
          m_left = m_left - 1;
        end
        if (m_busy && m_left == 0) begin
          m_busy = 0;
          m_ack  = 1;
          if (cmd) begin
            m_mem[int'(addr[IDX_W+1:2])] = wdata;
            m_rdata = '0;
            if (m_wr < 65535) m_wr++;
          end else begin
            m_rdata = m_mem[int'(addr[IDX_W+1:2])];
            if (m_rd < 65535) m_rd++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("s_out_vs_model", 64'(s_out), 64'({m_ack, m_rdata}));
`ifdef XBAR_SLV_STATS_EN
        check("rd_cnt_vs_model", 64'(rd_cnt), 64'(m_rd));
        check("wr_cnt_vs_model", 64'(wr_cnt), 64'(m_wr));
`endif
      end
    end
  end

  // Called at a negedge; returns at the negedge inside the ack cycle.
  task automatic txn(input logic c, input logic [31:0] a, input logic [31:0] d, input bit keep,
                     output logic [31:0] rd, output int lat);
    bit got;
    got = 0;
    lat = 0;
    rd  = 'x;
    req = 1'b1; cmd = c; addr = a; wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (s_out[32]) begin
        got = 1;
        rd  = s_out[31:0];
      end
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
    if (!keep) begin
      // junk on the bus while idle must not matter
      req = 1'b0; cmd = 1'b1; addr = 32'h5A5A_0008; wdata = 32'h1234_5678;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_reset", 64'(s_out), 64'd0);
    end

    txn(1'b0, 32'h0000_000C, 32'h0, 0, rd, lat);
    check("read_idx3_reset", 64'(rd), 64'h0);
    check("read_latency", 64'(lat), 64'(WAIT_CYC + 1));
    @(negedge clk);

    txn(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 0, rd, lat);
    check("write_rdata_zero", 64'(rd), 64'h0);
    check("write_latency", 64'(lat), 64'd3);
    @(negedge clk);
    check("ack_single_cycle", 64'(s_out), 64'd0);
    txn(1'b0, 32'h0000_0008, 32'h0, 0, rd, lat);
    check("read_back_deadbeef", 64'(rd), 64'hDEAD_BEEF);
    @(negedge clk);

    // back-to-back: new request presented right at the first ack
    txn(1'b1, 32'h0000_0004, 32'h1111_1111, 1, rd, lat);
    txn(1'b0, 32'h0000_0004, 32'h0, 0, rd, lat);
    check("b2b_rdata", 64'(rd), 64'h1111_1111);
    check("b2b_latency", 64'(lat), 64'(WAIT_CYC + 2));
    @(negedge clk);

    txn(1'b1, 32'h8000_0044, 32'hA5A5_A5A5, 0, rd, lat);
    @(negedge clk);
    txn(1'b0, 32'h0000_0004, 32'h0, 0, rd, lat);
    check("alias_read", 64'(rd), 64'hA5A5_A5A5);
    @(negedge clk);

    // abort: req dropped while waiting
    reset_dut();
    req = 1'b1; cmd = 1'b1; addr = 32'h0000_0008; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_ack", 64'(s_out[32]), 64'd0);
    end
    txn(1'b0, 32'h0000_0008, 32'h0, 0, rd, lat);
    check("abort_not_written", 64'(rd), 64'h0);
    @(negedge clk);

    // reset coinciding with the RESP-entry edge of a write
    txn(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 0, rd, lat);
    @(negedge clk);
    req = 1'b1; cmd = 1'b1; addr = 32'h0000_0010; wdata = 32'h1234_5678;
    repeat (WAIT_CYC) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_resp_no_ack", 64'(s_out), 64'd0);
    reset = 1'b0; req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_resp_quiet", 64'(s_out[32]), 64'd0);
    end
    txn(1'b0, 32'h0000_0010, 32'h0, 0, rd, lat);
    check("reset_resp_not_written", 64'(rd), 64'h0);
    @(negedge clk);

`ifdef XBAR_SLV_STATS_EN
    reset_dut();
    @(negedge clk);
    check("stats_rd_reset", 64'(rd_cnt), 64'd0);
    check("stats_wr_reset", 64'(wr_cnt), 64'd0);
    txn(1'b0, 32'h0, 32'h0, 0, rd, lat);   @(negedge clk);
    txn(1'b1, 32'h4, 32'h7, 0, rd, lat);   @(negedge clk);
    txn(1'b0, 32'h4, 32'h0, 0, rd, lat);   @(negedge clk);
    txn(1'b1, 32'h8, 32'h9, 0, rd, lat);   @(negedge clk);
    txn(1'b0, 32'h8, 32'h0, 0, rd, lat);   @(negedge clk);
    req = 1'b1; cmd = 1'b0; addr = 32'hC;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    check("stats_rd_final", 64'(rd_cnt), 64'd3);
    check("stats_wr_final", 64'(wr_cnt), 64'd2);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
